// File: rtl/rv32i_pkg.sv
// Shared RV32I execute-path types: shift operation encoding and data width.
package rv32i_pkg;

  localparam int XLEN_C = 32;

  typedef enum logic [1:0] {
    SHIFT_SLL  = 2'b00,
    SHIFT_SRL  = 2'b01,
    SHIFT_RSVD = 2'b10,
    SHIFT_SRA  = 2'b11
  } shift_op_e;

endpackage

// File: rtl/shift_pipe_stage.sv
// Combinational shift slice: shifts by LSB_WEIGHT * shamt.
// SRA fills from 'fill'; the reserved op passes data through unchanged.
module shift_pipe_stage
  import rv32i_pkg::*;
#(
  parameter int XLEN       = XLEN_C,
  parameter int LSB_WEIGHT = 1,
  parameter int SHAMT_W    = 3
) (
  input  logic [XLEN-1:0]    data,
  input  shift_op_e          op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               fill,
  output logic [XLEN-1:0]    shifted
);

  logic [4:0]      amt;
  logic [XLEN-1:0] fill_mask;

  assign amt = 5'(shamt) * 5'(LSB_WEIGHT);

  always_comb begin
    fill_mask = fill ? ~({XLEN{1'b1}} >> amt) : '0;
    case (op)
      SHIFT_SLL: shifted = data << amt;
      SHIFT_SRL: shifted = data >> amt;
      SHIFT_SRA: shifted = (data >> amt) | fill_mask;
      default:   shifted = data;
    endcase
  end

endmodule

// File: rtl/shift_exec_pipe.sv
// Two-stage RV32I shift unit: S1 shifts by shamt[2:0], S2 by 8*shamt[4:3].
// Valid/ready on both sides with a flush that kills every in-flight entry.
module shift_exec_pipe
  import rv32i_pkg::*;
#(
  parameter int XLEN  = XLEN_C,
  parameter int TAG_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [1:0]       i_op,
  input  logic [XLEN-1:0]  i_a,
  input  logic [4:0]       i_shamt,
  input  logic [TAG_W-1:0] i_rd,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [XLEN-1:0]  o_result,
  output logic [TAG_W-1:0] o_rd
);

  logic             ready_en;
  logic             s1_valid;
  logic             s2_valid;
  logic             s2_adv;
  logic             accept;
  shift_op_e        op_in;
  shift_op_e        s1_op;
  logic [XLEN-1:0]  s1_data;
  logic [1:0]       s1_shamt_hi;
  logic [TAG_W-1:0] s1_rd;
  logic [XLEN-1:0]  s1_next;
  logic [XLEN-1:0]  s2_next;

  assign op_in   = shift_op_e'(i_op);
  assign s2_adv  = s1_valid && (!s2_valid || i_ready);
  assign o_ready = ready_en && !i_flush && (!s1_valid || s2_adv);
  assign accept  = i_valid && o_ready;
  assign o_valid = s2_valid;

  shift_pipe_stage #(
    .XLEN       (XLEN),
    .LSB_WEIGHT (1),
    .SHAMT_W    (3)
  ) u_stage1 (
    .data    (i_a),
    .op      (op_in),
    .shamt   (i_shamt[2:0]),
    .fill    (i_a[XLEN-1]),
    .shifted (s1_next)
  );

  // The partial value keeps the sign bit, so S2 can fill SRA from it.
  shift_pipe_stage #(
    .XLEN       (XLEN),
    .LSB_WEIGHT (8),
    .SHAMT_W    (2)
  ) u_stage2 (
    .data    (s1_data),
    .op      (s1_op),
    .shamt   (s1_shamt_hi),
    .fill    (s1_data[XLEN-1]),
    .shifted (s2_next)
  );

  // Keeps o_ready low until the first edge after reset release.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) ready_en <= 1'b0;
    else          ready_en <= 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid    <= 1'b0;
      s1_data     <= '0;
      s1_op       <= SHIFT_SLL;
      s1_shamt_hi <= '0;
      s1_rd       <= '0;
    end else if (i_flush) begin
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_valid    <= 1'b1;
      s1_data     <= s1_next;
      s1_op       <= op_in;
      s1_shamt_hi <= i_shamt[4:3];
      s1_rd       <= i_rd;
    end else if (s2_adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2_valid <= 1'b0;
      o_result <= '0;
      o_rd     <= '0;
    end else if (i_flush) begin
      s2_valid <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= 1'b1;
      o_result <= s2_next;
      o_rd     <= s1_rd;
    end else if (s2_valid && i_ready) begin
      s2_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_exec_pipe.sv
// Directed self-checking bench for shift_exec_pipe: results, latency,
// throughput, backpressure, flush and mid-operation reset.
module tb_shift_exec_pipe;

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRL  = 2'b01;
  localparam logic [1:0] OP_RSVD = 2'b10;
  localparam logic [1:0] OP_SRA  = 2'b11;

  logic        clk;
  logic        rst_n;
  logic        valid_in;
  logic        ready_out;
  logic [1:0]  op;
  logic [31:0] a;
  logic [4:0]  shamt;
  logic [4:0]  rd;
  logic        flush;
  logic        valid_out;
  logic        ready_in;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int num_checks = 0;
  int num_fails  = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [4:0]  sh;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[16];
  logic [1:0]  b2b_ops[3];
  logic [31:0] b2b_exp[8];

  shift_exec_pipe #(.XLEN(32), .TAG_W(5)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_valid  (valid_in),
    .o_ready  (ready_out),
    .i_op     (op),
    .i_a      (a),
    .i_shamt  (shamt),
    .i_rd     (rd),
    .i_flush  (flush),
    .o_valid  (valid_out),
    .i_ready  (ready_in),
    .o_result (result),
    .o_rd     (rd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Drives one cycle of inputs just after a falling edge, then settles.
  task automatic applyStimulus(input logic v, input logic [1:0] o, input logic [31:0] x,
                               input logic [4:0] s, input logic [4:0] t,
                               input logic fl, input logic rdy);
    valid_in = v;
    op       = o;
    a        = x;
    shamt    = s;
    rd       = t;
    flush    = fl;
    ready_in = rdy;
    #1;
  endtask

  task automatic idle(input logic rdy);
    applyStimulus(1'b0, OP_SLL, 32'h0, 5'd0, 5'd0, 1'b0, rdy);
  endtask

  function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] x, input logic [4:0] s);
    case (o)
      OP_SLL:  return x << s;
      OP_SRL:  return x >> s;
      OP_SRA:  return 32'($signed(x) >>> s);
      default: return x;
    endcase
  endfunction

  task automatic run_single(input string tag, input logic [1:0] o, input logic [31:0] x,
                            input logic [4:0] s, input logic [4:0] t, input logic [31:0] exp);
    @(negedge clk);
    applyStimulus(1'b1, o, x, s, t, 1'b0, 1'b1);
    checkOutput({tag, "_ready"}, 32'(ready_out), 32'd1);
    @(negedge clk);
    idle(1'b1);
    checkOutput({tag, "_valid_c1"}, 32'(valid_out), 32'd0);
    @(negedge clk);
    idle(1'b1);
    checkOutput({tag, "_valid_c2"}, 32'(valid_out), 32'd1);
    checkOutput({tag, "_result"}, result, exp);
    checkOutput({tag, "_rd"}, 32'(rd_out), 32'(t));
  endtask

  initial begin
    vecs = '{
      '{OP_SLL,  32'h0000_0001, 5'd31, 32'h8000_0000},
      '{OP_SLL,  32'h1234_5678, 5'd4,  32'h2345_6780},
      '{OP_SRL,  32'h8000_0000, 5'd4,  32'h0800_0000},
      '{OP_SRA,  32'h8000_0000, 5'd4,  32'hF800_0000},
      '{OP_SRA,  32'hF000_0000, 5'd31, 32'hFFFF_FFFF},
      '{OP_SLL,  32'hF000_0000, 5'd0,  32'hF000_0000},
      '{OP_SRL,  32'hF000_0000, 5'd0,  32'hF000_0000},
      '{OP_SRA,  32'hF000_0000, 5'd0,  32'hF000_0000},
      '{OP_RSVD, 32'hDEAD_BEEF, 5'd7,  32'hDEAD_BEEF},
      '{OP_SRL,  32'hF000_0000, 5'd31, 32'h0000_0001},
      '{OP_SLL,  32'h1234_5678, 5'd12, 32'h4567_8000},
      '{OP_SRA,  32'h8000_0001, 5'd17, 32'hFFFF_C000},
      '{OP_SRA,  32'h7FFF_FFFF, 5'd9,  32'h003F_FFFF},
      '{OP_SRL,  32'h8765_4321, 5'd20, 32'h0000_0876},
      '{OP_SLL,  32'h8765_4321, 5'd27, 32'h0800_0000},
      '{OP_RSVD, 32'h1234_5678, 5'd31, 32'h1234_5678}
    };
    b2b_ops = '{OP_SLL, OP_SRL, OP_SRA};

    // Reset state
    rst_n = 1'b0;
    applyStimulus(1'b1, OP_SLL, 32'h1, 5'd1, 5'd1, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("rst_valid", 32'(valid_out), 32'd0);
    checkOutput("rst_result", result, 32'd0);
    checkOutput("rst_rd", 32'(rd_out), 32'd0);
    checkOutput("rst_ready", 32'(ready_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1'b1);
    checkOutput("rst_release_ready", 32'(ready_out), 32'd0);
    @(negedge clk);
    idle(1'b1);
    checkOutput("rst_ready_rise", 32'(ready_out), 32'd1);

    // Directed single ops, 2-cycle latency each
    for (int i = 0; i < 16; i++)
      run_single($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].sh, 5'(i + 1), vecs[i].exp);

    // Back-to-back throughput, tags 1..8
    for (int i = 0; i < 8; i++)
      b2b_exp[i] = ref_shift(b2b_ops[i % 3], 32'h8765_4321, 5'(3 * i + 1));
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (cyc < 8)
        applyStimulus(1'b1, b2b_ops[cyc % 3], 32'h8765_4321, 5'(3 * cyc + 1), 5'(cyc + 1), 1'b0, 1'b1);
      else
        idle(1'b1);
      if (cyc < 8) checkOutput($sformatf("b2b_ready%0d", cyc), 32'(ready_out), 32'd1);
      if (cyc < 2) begin
        checkOutput($sformatf("b2b_valid%0d", cyc), 32'(valid_out), 32'd0);
      end else begin
        checkOutput($sformatf("b2b_valid%0d", cyc), 32'(valid_out), 32'd1);
        checkOutput($sformatf("b2b_rd%0d", cyc), 32'(rd_out), 32'(cyc - 1));
        checkOutput($sformatf("b2b_result%0d", cyc), result, b2b_exp[cyc - 2]);
      end
    end
    @(negedge clk);
    idle(1'b1);
    checkOutput("b2b_drained", 32'(valid_out), 32'd0);

    // Backpressure: A, B accepted, C stalls until i_ready returns
    @(negedge clk);
    applyStimulus(1'b1, OP_SLL, 32'h0000_00FF, 5'd8, 5'd10, 1'b0, 1'b0);
    checkOutput("bp_ready0", 32'(ready_out), 32'd1);
    @(negedge clk);
    applyStimulus(1'b1, OP_SRA, 32'h8000_0000, 5'd12, 5'd11, 1'b0, 1'b0);
    checkOutput("bp_ready1", 32'(ready_out), 32'd1);
    for (int cyc = 2; cyc < 4; cyc++) begin
      @(negedge clk);
      applyStimulus(1'b1, OP_SRL, 32'hFFFF_FFFF, 5'd28, 5'd12, 1'b0, 1'b0);
      checkOutput($sformatf("bp_full_ready%0d", cyc), 32'(ready_out), 32'd0);
      checkOutput($sformatf("bp_stall_valid%0d", cyc), 32'(valid_out), 32'd1);
      checkOutput($sformatf("bp_stall_result%0d", cyc), result, 32'h0000_FF00);
      checkOutput($sformatf("bp_stall_rd%0d", cyc), 32'(rd_out), 32'd10);
    end
    @(negedge clk);
    applyStimulus(1'b1, OP_SRL, 32'hFFFF_FFFF, 5'd28, 5'd12, 1'b0, 1'b1);
    checkOutput("bp_resume_ready", 32'(ready_out), 32'd1);
    checkOutput("bp_retire_a_rd", 32'(rd_out), 32'd10);
    checkOutput("bp_retire_a_res", result, 32'h0000_FF00);
    @(negedge clk);
    idle(1'b1);
    checkOutput("bp_retire_b_valid", 32'(valid_out), 32'd1);
    checkOutput("bp_retire_b_rd", 32'(rd_out), 32'd11);
    checkOutput("bp_retire_b_res", result, 32'hFFF8_0000);
    @(negedge clk);
    idle(1'b1);
    checkOutput("bp_retire_c_valid", 32'(valid_out), 32'd1);
    checkOutput("bp_retire_c_rd", 32'(rd_out), 32'd12);
    checkOutput("bp_retire_c_res", result, 32'h0000_000F);
    @(negedge clk);
    idle(1'b1);
    checkOutput("bp_drained", 32'(valid_out), 32'd0);

    // Flush with two entries in flight and a new request presented
    @(negedge clk);
    applyStimulus(1'b1, OP_SLL, 32'h1111_1111, 5'd1, 5'd20, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, OP_SRL, 32'h2222_2222, 5'd2, 5'd21, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, OP_SRA, 32'h3333_3333, 5'd3, 5'd22, 1'b1, 1'b0);
    checkOutput("fl_ready", 32'(ready_out), 32'd0);
    @(negedge clk);
    applyStimulus(1'b1, OP_SRA, 32'hC000_0000, 5'd1, 5'd23, 1'b0, 1'b1);
    checkOutput("fl_valid_after", 32'(valid_out), 32'd0);
    checkOutput("fl_resume_ready", 32'(ready_out), 32'd1);
    @(negedge clk);
    idle(1'b1);
    checkOutput("fl_valid_c1", 32'(valid_out), 32'd0);
    @(negedge clk);
    idle(1'b1);
    checkOutput("fl_new_valid", 32'(valid_out), 32'd1);
    checkOutput("fl_new_rd", 32'(rd_out), 32'd23);
    checkOutput("fl_new_result", result, 32'hE000_0000);
    @(negedge clk);
    idle(1'b1);
    checkOutput("fl_no_ghost", 32'(valid_out), 32'd0);

    // Asynchronous reset with both stages full
    @(negedge clk);
    applyStimulus(1'b1, OP_SLL, 32'h0000_0005, 5'd1, 5'd30, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, OP_SLL, 32'h0000_0006, 5'd1, 5'd31, 1'b0, 1'b0);
    @(negedge clk);
    idle(1'b0);
    checkOutput("mr_full_valid", 32'(valid_out), 32'd1);
    checkOutput("mr_full_rd", 32'(rd_out), 32'd30);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mr_valid", 32'(valid_out), 32'd0);
    checkOutput("mr_result", result, 32'd0);
    checkOutput("mr_rd", 32'(rd_out), 32'd0);
    checkOutput("mr_ready", 32'(ready_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1'b1);
    checkOutput("mr_release_ready", 32'(ready_out), 32'd0);
    run_single("mr_first", OP_SLL, 32'h0000_0003, 5'd30, 5'd7, 32'hC000_0000);
    @(negedge clk);
    idle(1'b1);
    checkOutput("mr_no_stale", 32'(valid_out), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
